btn_speed_ctrl: RTL

//  Conditions the three raw board pushbuttons (speed up, speed down, pause) in the clk50 domain.

---
 rtl/btn_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 55 +++++
 rtl/btn_speed_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants, speed-level type and saturating step helper for the
// pushbutton speed/pause controller.
package btn_pkg;

    localparam int SPEED_W            = 2;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int CNT_W_DEFAULT      = 20;
    localparam int RPT_CYCLES_DEFAULT = 25_000_000;

    typedef logic [SPEED_W-1:0] speed_t;

    localparam speed_t SPEED_LVL_MIN = 2'd0;
    localparam speed_t SPEED_LVL_MAX = 2'd3;

    // Opposing requests in the same cycle cancel; otherwise step and saturate.
    function automatic speed_t speed_step(input speed_t lvl, input logic up, input logic dn);
        speed_t nxt;
        nxt = lvl;
        if (up && !dn) begin
            if (lvl != SPEED_LVL_MAX) begin
                nxt = lvl + 2'd1;
            end else begin
                nxt = lvl;
            end
        end else if (dn && !up) begin
            if (lvl != SPEED_LVL_MIN) begin
                nxt = lvl - 2'd1;
            end else begin
                nxt = lvl;
            end
        end else begin
            nxt = lvl;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchroniser, restart-on-bounce debouncer and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rs,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES straight cycles.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            cnt_r      <= {CNT_W{1'b0}};
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DEB_CYCLES - 1)) begin
                stable_r <= sync2_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign btn_level = stable_r;
    assign btn_press = stable_r & ~stable_d_r;

endmodule

// File: rtl/btn_speed_ctrl.sv
// Speed/pause controller fed by three debounced buttons.
// Optional auto-repeat on held up/down buttons: define BTN_AUTO_REPEAT_EN.
module btn_speed_ctrl
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
`ifdef BTN_AUTO_REPEAT_EN
   ,parameter int RPT_CYCLES = RPT_CYCLES_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               rs,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic               btn_pause,
    output logic               speed1,
    output logic               speed2,
    output logic               pause,
    output logic [SPEED_W-1:0] speed_lvl
);

    logic   up_level_s;
    logic   dn_level_s;
    logic   pause_level_unused_s;
    logic   up_press_s;
    logic   dn_press_s;
    logic   pause_press_s;
    logic   up_ev_s;
    logic   dn_ev_s;
    speed_t speed_lvl_r;
    logic   pause_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
        .clk(clk), .rs(rs), .btn_raw(btn_up),
        .btn_level(up_level_s), .btn_press(up_press_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
        .clk(clk), .rs(rs), .btn_raw(btn_dn),
        .btn_level(dn_level_s), .btn_press(dn_press_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_pause (
        .clk(clk), .rs(rs), .btn_raw(btn_pause),
        .btn_level(pause_level_unused_s), .btn_press(pause_press_s)
    );

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_W = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;

    logic [RPT_W-1:0] up_rpt_cnt_r;
    logic [RPT_W-1:0] dn_rpt_cnt_r;
    logic             up_rpt_s;
    logic             dn_rpt_s;

    assign up_rpt_s = up_level_s && (up_rpt_cnt_r == RPT_W'(RPT_CYCLES - 1));
    assign dn_rpt_s = dn_level_s && (dn_rpt_cnt_r == RPT_W'(RPT_CYCLES - 1));

    // Repeat timers restart on release, on the initial press and on each repeat.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            up_rpt_cnt_r <= {RPT_W{1'b0}};
            dn_rpt_cnt_r <= {RPT_W{1'b0}};
        end else begin
            if (!up_level_s || up_press_s || up_rpt_s) begin
                up_rpt_cnt_r <= {RPT_W{1'b0}};
            end else begin
                up_rpt_cnt_r <= up_rpt_cnt_r + RPT_W'(1);
            end
            if (!dn_level_s || dn_press_s || dn_rpt_s) begin
                dn_rpt_cnt_r <= {RPT_W{1'b0}};
            end else begin
                dn_rpt_cnt_r <= dn_rpt_cnt_r + RPT_W'(1);
            end
        end
    end

    // Merge first-press and repeat requests.
    always_comb begin
        up_ev_s = up_press_s | up_rpt_s;
        dn_ev_s = dn_press_s | dn_rpt_s;
    end
`else
    logic [1:0] hold_unused_s;
    assign hold_unused_s = {up_level_s, dn_level_s};

    // One request per accepted press.
    always_comb begin
        up_ev_s = up_press_s;
        dn_ev_s = dn_press_s;
    end
`endif

    // Saturating speed level and pause toggle; both update in the same cycle.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            speed_lvl_r <= SPEED_LVL_MIN;
            pause_r     <= 1'b0;
        end else begin
            speed_lvl_r <= speed_step(speed_lvl_r, up_ev_s, dn_ev_s);
            pause_r     <= pause_r ^ pause_press_s;
        end
    end

    assign speed_lvl = speed_lvl_r;
    assign speed1    = speed_lvl_r[0];
    assign speed2    = speed_lvl_r[1];
    assign pause     = pause_r;

endmodule
